// File: rtl/ascii_number_emitter_if.sv
// Handshake bundle between the number emitter and its downstream character consumer.
// The emitter is the stream source and takes the master modport.
interface ascii_number_emitter_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] value;
    logic [7:0]       ascii_char;
    logic             valid;
    logic             ready;
    logic             busy;
    logic             done;

    modport master (
        input  start, value, ready,
        output ascii_char, valid, busy, done
    );

    modport slave (
        output start, value, ready,
        input  ascii_char, valid, busy, done
    );
endinterface

// File: rtl/ascii_number_emitter.sv
// Serial double-dabble binary-to-decimal converter that streams the result as NUL-terminated
// ASCII digits, most significant first, with leading zeros suppressed.
module ascii_number_emitter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    ascii_number_emitter_if.master bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_LOCATE,
        S_SEND,
        S_TERM
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   bin_r;
    logic [BCD_W-1:0]   bcd_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   idx_r;
    logic [7:0]         ascii_char_r;
    logic               valid_r;
    logic               busy_r;
    logic               done_r;
    logic [BCD_W-1:0]   bcd_adj_s;
    logic [IDX_W-1:0]   msd_idx_s;

    // Double-dabble correction: any nibble >= 5 would overflow past 9 once doubled.
    function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[d*4 +: 4] >= 4'd5) res[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
            else                       res[d*4 +: 4] = bcd[d*4 +: 4];
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] msd_index(input logic [BCD_W-1:0] bcd);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[d*4 +: 4] != 4'd0) idx = IDX_W'(d);
            else                       idx = idx;
        end
        return idx;
    endfunction

    function automatic logic [3:0] nibble_at(input logic [BCD_W-1:0] bcd,
                                             input logic [IDX_W-1:0] idx);
        logic [3:0] nib;
        nib = 4'd0;
        for (int d = 0; d < DIGITS; d++) begin
            if (idx == IDX_W'(d)) nib = bcd[d*4 +: 4];
            else                  nib = nib;
        end
        return nib;
    endfunction

    function automatic logic [7:0] to_ascii(input logic [3:0] nib);
        return 8'h30 + {4'h0, nib};
    endfunction

    assign bcd_adj_s = add3_all(bcd_r);
    assign msd_idx_s = msd_index(bcd_r);

    // Conversion and emission state machine; every output is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            bin_r        <= {WIDTH{1'b0}};
            bcd_r        <= {BCD_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            ascii_char_r <= 8'h00;
            valid_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        bin_r   <= bus.value;
                        bcd_r   <= {BCD_W{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    bcd_r <= {bcd_adj_s[BCD_W-2:0], bin_r[WIDTH-1]};
                    bin_r <= {bin_r[WIDTH-2:0], 1'b0};
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_LAST) state_r <= S_LOCATE;
                end
                S_LOCATE: begin
                    // An all-zero register yields index 0, so zero still emits one '0'.
                    idx_r        <= msd_idx_s;
                    ascii_char_r <= to_ascii(nibble_at(bcd_r, msd_idx_s));
                    valid_r      <= 1'b1;
                    state_r      <= S_SEND;
                end
                S_SEND: begin
                    if (bus.ready) begin
                        if (idx_r == {IDX_W{1'b0}}) begin
                            ascii_char_r <= 8'h00;
                            state_r      <= S_TERM;
                        end else begin
                            idx_r        <= idx_r - IDX_W'(1);
                            ascii_char_r <= to_ascii(nibble_at(bcd_r, idx_r - IDX_W'(1)));
                        end
                    end
                end
                S_TERM: begin
                    if (bus.ready) begin
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    ascii_char_r <= 8'h00;
                    valid_r      <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ascii_char = ascii_char_r;
    assign bus.valid      = valid_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
endmodule
